// File: rtl/corner_tracker_pkg.sv
// rtl/corner_tracker_pkg.sv - shared coordinate/key/count widths, FSM states and default corner constants
package corner_tracker_pkg;

    localparam int COORD_W = 11;
    localparam int KEY_W   = 12;
    localparam int COUNT_W = 19;

    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic [KEY_W-1:0]          skey_t;
    typedef logic signed [KEY_W-1:0]   dkey_t;
    typedef logic [COUNT_W-1:0]        count_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [1:0] {C_TL, C_TR, C_BL, C_BR} corner_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_COMMIT} state_t;

    // Corners of the full frame, used until the first valid frame commits.
    function automatic point_t default_corner(input corner_t c, input int width, input int height);
        point_t p;
        coord_t right;
        coord_t bottom;
        right  = coord_t'(width - 1);
        bottom = coord_t'(height - 1);
        p.x = (c == C_TR || c == C_BR) ? right  : '0;
        p.y = (c == C_BL || c == C_BR) ? bottom : '0;
        return p;
    endfunction

endpackage

// File: rtl/corner_tracker_marker_classify.sv
// rtl/corner_tracker_marker_classify.sv - combinational red-marker colour test
module marker_classify (
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic [7:0] r_min,
    input  logic [7:0] g_max,
    input  logic [7:0] b_max,
    output logic       is_marker
);

    always_comb begin
        is_marker = (pix_r >= r_min) && (pix_g <= g_max) && (pix_b <= b_max);
    end

endmodule

// File: rtl/corner_tracker.sv
// rtl/corner_tracker.sv - per-frame extreme-corner search over marker pixels with committed outputs
module corner_tracker
    import corner_tracker_pkg::*;
#(
    parameter int         p_frame_width  = 640,
    parameter int         p_frame_height = 480,
    parameter int         p_min_count    = 16,
    parameter logic [7:0] p_r_min        = 8'd160,
    parameter logic [7:0] p_g_max        = 8'd80,
    parameter logic [7:0] p_b_max        = 8'd80
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] VGA_X,
    input  logic [COORD_W-1:0] VGA_Y,
    input  logic [7:0]         pix_R,
    input  logic [7:0]         pix_G,
    input  logic [7:0]         pix_B,
    output logic [COORD_W-1:0] top_left_x,
    output logic [COORD_W-1:0] top_left_y,
    output logic [COORD_W-1:0] top_right_x,
    output logic [COORD_W-1:0] top_right_y,
    output logic [COORD_W-1:0] bot_left_x,
    output logic [COORD_W-1:0] bot_left_y,
    output logic [COORD_W-1:0] bot_right_x,
    output logic [COORD_W-1:0] bot_right_y,
    output logic               corners_valid,
    output logic               frame_done
);

    localparam coord_t LAST_X    = coord_t'(p_frame_width - 1);
    localparam coord_t LAST_Y    = coord_t'(p_frame_height - 1);
    localparam count_t MIN_COUNT = count_t'(p_min_count);
    localparam point_t DEF_TL    = default_corner(C_TL, p_frame_width, p_frame_height);
    localparam point_t DEF_TR    = default_corner(C_TR, p_frame_width, p_frame_height);
    localparam point_t DEF_BL    = default_corner(C_BL, p_frame_width, p_frame_height);
    localparam point_t DEF_BR    = default_corner(C_BR, p_frame_width, p_frame_height);

    logic   color_hit;
    logic   in_range;
    logic   s1_valid;
    logic   s1_marker;
    coord_t s1_x;
    coord_t s1_y;
    state_t state;
    state_t state_next;
    logic   start;
    logic   accum;
    logic   hit;
    logic   fresh;
    logic   is_origin;
    logic   is_last;
    skey_t  s_key;
    dkey_t  d_key;
    point_t cur;
    count_t count;
    skey_t  tl_key;
    skey_t  br_key;
    dkey_t  tr_key;
    dkey_t  bl_key;
    point_t tl_pt;
    point_t tr_pt;
    point_t bl_pt;
    point_t br_pt;

    marker_classify u_classify (
        .pix_r     (pix_R),
        .pix_g     (pix_G),
        .pix_b     (pix_B),
        .r_min     (p_r_min),
        .g_max     (p_g_max),
        .b_max     (p_b_max),
        .is_marker (color_hit)
    );

    assign in_range = (VGA_X <= LAST_X) && (VGA_Y <= LAST_Y);

    // Input stage; this extra register sets the two-edge commit latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pixel_valid && in_range;
        end
        if (pixel_valid) begin
            s1_x      <= VGA_X;
            s1_y      <= VGA_Y;
            s1_marker <= color_hit;
        end
    end

    assign is_origin = (s1_x == '0) && (s1_y == '0);
    assign is_last   = (s1_x == LAST_X) && (s1_y == LAST_Y);
    assign s_key     = {1'b0, s1_x} + {1'b0, s1_y};
    assign d_key     = $signed({1'b0, s1_x}) - $signed({1'b0, s1_y});
    assign cur       = {s1_x, s1_y};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        accum      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s1_valid && is_origin) begin
                    start      = 1'b1;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (s1_valid) begin
                    if (is_origin) begin
                        start = 1'b1;
                    end else begin
                        accum = s1_marker;
                        if (is_last) begin
                            state_next = ST_COMMIT;
                        end
                    end
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // An empty count means the trackers hold stale data, so the first marker always loads.
    assign hit   = (start && s1_marker) || accum;
    assign fresh = start || (count == '0);

    always_ff @(posedge clk) begin
        if (hit && (fresh || s_key < tl_key)) begin
            tl_key <= s_key;
            tl_pt  <= cur;
        end
        if (hit && (fresh || s_key > br_key)) begin
            br_key <= s_key;
            br_pt  <= cur;
        end
        if (hit && (fresh || d_key > tr_key)) begin
            tr_key <= d_key;
            tr_pt  <= cur;
        end
        if (hit && (fresh || d_key < bl_key)) begin
            bl_key <= d_key;
            bl_pt  <= cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            frame_done    <= 1'b0;
            corners_valid <= 1'b0;
            top_left_x    <= DEF_TL.x;
            top_left_y    <= DEF_TL.y;
            top_right_x   <= DEF_TR.x;
            top_right_y   <= DEF_TR.y;
            bot_left_x    <= DEF_BL.x;
            bot_left_y    <= DEF_BL.y;
            bot_right_x   <= DEF_BR.x;
            bot_right_y   <= DEF_BR.y;
        end else begin
            frame_done <= (state == ST_COMMIT);
            if (start) begin
                count <= {{(COUNT_W-1){1'b0}}, s1_marker};
            end else if (accum && count != '1) begin
                count <= count + count_t'(1);
            end
            if (state == ST_COMMIT) begin
                corners_valid <= (count >= MIN_COUNT);
                if (count >= MIN_COUNT) begin
                    top_left_x  <= tl_pt.x;
                    top_left_y  <= tl_pt.y;
                    top_right_x <= tr_pt.x;
                    top_right_y <= tr_pt.y;
                    bot_left_x  <= bl_pt.x;
                    bot_left_y  <= bl_pt.y;
                    bot_right_x <= br_pt.x;
                    bot_right_y <= br_pt.y;
                end
            end
        end
    end

endmodule

// File: tb/tb_corner_tracker.sv
// tb/tb_corner_tracker.sv - directed scoreboard bench for corner_tracker on a reduced 40x30 frame
module tb_corner_tracker;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int MIN = 16;

    localparam int K_RECT  = 0;
    localparam int K_FEW   = 1;
    localparam int K_TIE   = 2;
    localparam int K_PART  = 3;
    localparam int K_RECT2 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [10:0] VGA_X = '0;
    logic [10:0] VGA_Y = '0;
    logic [7:0]  pix_R = '0;
    logic [7:0]  pix_G = '0;
    logic [7:0]  pix_B = '0;
    logic [10:0] top_left_x, top_left_y, top_right_x, top_right_y;
    logic [10:0] bot_left_x, bot_left_y, bot_right_x, bot_right_y;
    logic        corners_valid;
    logic        frame_done;

    corner_tracker #(
        .p_frame_width  (W),
        .p_frame_height (H),
        .p_min_count    (MIN),
        .p_r_min        (8'd160),
        .p_g_max        (8'd80),
        .p_b_max        (8'd80)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_valid   (pixel_valid),
        .VGA_X         (VGA_X),
        .VGA_Y         (VGA_Y),
        .pix_R         (pix_R),
        .pix_G         (pix_G),
        .pix_B         (pix_B),
        .top_left_x    (top_left_x),
        .top_left_y    (top_left_y),
        .top_right_x   (top_right_x),
        .top_right_y   (top_right_y),
        .bot_left_x    (bot_left_x),
        .bot_left_y    (bot_left_y),
        .bot_right_x   (bot_right_x),
        .bot_right_y   (bot_right_y),
        .corners_valid (corners_valid),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] tl_x, tl_y, tr_x, tr_y, bl_x, bl_y, br_x, br_y;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total = 0;
    int   fd_count = 0;
    int   f0;

    always @(posedge clk) begin
        if (frame_done) fd_count <= fd_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int tlx, tly, trx, try_v, blx, bly, brx, bry, input logic v);
        exp_t e;
        e.tl_x = 11'(tlx); e.tl_y = 11'(tly);
        e.tr_x = 11'(trx); e.tr_y = 11'(try_v);
        e.bl_x = 11'(blx); e.bl_y = 11'(bly);
        e.br_x = 11'(brx); e.br_y = 11'(bry);
        e.valid = v;
        return e;
    endfunction

    function automatic logic is_mark(input int kind, input int x, input int y);
        case (kind)
            K_RECT:  return x >= 10 && x <= 19 && y >= 5 && y <= 14;
            K_FEW:   return y == 3 && x >= 5 && x <= 14;
            K_TIE:   return (x == 10 && y == 20) || (x == 20 && y == 10) || (y == 28 && x >= 20 && x <= 33);
            K_PART:  return x >= 30 && x <= 35 && y <= 19;
            K_RECT2: return x >= 2 && x <= 6 && y >= 22 && y <= 25;
            default: return 1'b0;
        endcase
    endfunction

    // Markers alternate between threshold-edge and saturated colours; background sits just outside each threshold.
    task automatic put_pixel(input int x, input int y, input logic mark, input logic valid);
        @(negedge clk);
        pixel_valid = valid;
        VGA_X = 11'(x);
        VGA_Y = 11'(y);
        if (mark) begin
            pix_R = (x % 2 == 1) ? 8'd160 : 8'd255;
            pix_G = (x % 2 == 1) ? 8'd80  : 8'd0;
            pix_B = (x % 2 == 1) ? 8'd80  : 8'd3;
        end else begin
            case ((x + y) % 4)
                0:       begin pix_R = 8'd159; pix_G = 8'd0;  pix_B = 8'd0;  end
                1:       begin pix_R = 8'd255; pix_G = 8'd81; pix_B = 8'd0;  end
                2:       begin pix_R = 8'd255; pix_G = 8'd0;  pix_B = 8'd81; end
                default: begin pix_R = 8'd0;   pix_G = 8'd0;  pix_B = 8'd0;  end
            endcase
        end
    endtask

    task automatic drive_lines(input int kind, input logic tog, input int y0, input int y1, input logic oor);
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < W; x++) begin
                if (tog) put_pixel((x % 2 == 1) ? W - 1 : 0, (x % 2 == 1) ? H - 1 : 0, 1'b1, 1'b0);
                put_pixel(x, y, is_mark(kind, x, y), 1'b1);
            end
            if (oor && y < H - 1) begin
                put_pixel(W, y, 1'b1, 1'b1);
                put_pixel(W + 1, y, 1'b1, 1'b1);
                put_pixel(3, H, 1'b1, 1'b1);
            end
        end
    endtask

    task automatic expect_commit(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            pixel_valid = 1'b0;
            n++;
        end while (!frame_done && n < 8);
        check({tag, ".latency"}, n, 3);
        check({tag, ".frame_done"}, frame_done, 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, ".tl_x"}, top_left_x, e.tl_x);
        check({tag, ".tl_y"}, top_left_y, e.tl_y);
        check({tag, ".tr_x"}, top_right_x, e.tr_x);
        check({tag, ".tr_y"}, top_right_y, e.tr_y);
        check({tag, ".bl_x"}, bot_left_x, e.bl_x);
        check({tag, ".bl_y"}, bot_left_y, e.bl_y);
        check({tag, ".br_x"}, bot_right_x, e.br_x);
        check({tag, ".br_y"}, bot_right_y, e.br_y);
        check({tag, ".valid"}, corners_valid, e.valid);
        @(negedge clk);
        check({tag, ".pulse_end"}, frame_done, 0);
    endtask

    task automatic check_defaults(input string tag);
        check({tag, ".tl_x"}, top_left_x, 0);
        check({tag, ".tl_y"}, top_left_y, 0);
        check({tag, ".tr_x"}, top_right_x, W - 1);
        check({tag, ".tr_y"}, top_right_y, 0);
        check({tag, ".bl_x"}, bot_left_x, 0);
        check({tag, ".bl_y"}, bot_left_y, H - 1);
        check({tag, ".br_x"}, bot_right_x, W - 1);
        check({tag, ".br_y"}, bot_right_y, H - 1);
        check({tag, ".valid"}, corners_valid, 0);
        check({tag, ".frame_done"}, frame_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_defaults("reset");
        reset = 1'b0;

        sb.push_back(mk(10, 5, 19, 5, 10, 14, 19, 14, 1'b1));
        f0 = fd_count;
        drive_lines(K_RECT, 1'b0, 0, H - 1, 1'b0);
        expect_commit("rect");
        check("rect.one_pulse", fd_count - f0, 1);

        sb.push_back(mk(10, 5, 19, 5, 10, 14, 19, 14, 1'b0));
        drive_lines(K_FEW, 1'b0, 0, H - 1, 1'b0);
        expect_commit("few");

        sb.push_back(mk(20, 10, 20, 10, 10, 20, 33, 28, 1'b1));
        drive_lines(K_TIE, 1'b0, 0, H - 1, 1'b0);
        expect_commit("tie");

        f0 = fd_count;
        drive_lines(K_PART, 1'b0, 0, 19, 1'b0);
        repeat (4) begin
            @(negedge clk);
            pixel_valid = 1'b0;
        end
        check("restart.no_done", fd_count - f0, 0);
        sb.push_back(mk(2, 22, 6, 22, 2, 25, 6, 25, 1'b1));
        drive_lines(K_RECT2, 1'b0, 0, H - 1, 1'b0);
        expect_commit("restart");
        check("restart.one_pulse", fd_count - f0, 1);

        drive_lines(K_RECT, 1'b0, 0, 14, 1'b0);
        @(negedge clk);
        pixel_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_defaults("midreset");
        f0 = fd_count;
        drive_lines(K_RECT, 1'b0, 15, H - 1, 1'b0);
        repeat (6) begin
            @(negedge clk);
            pixel_valid = 1'b0;
        end
        check("midreset.no_done", fd_count - f0, 0);
        check_defaults("midreset.after");

        sb.push_back(mk(10, 5, 19, 5, 10, 14, 19, 14, 1'b1));
        drive_lines(K_RECT, 1'b1, 0, H - 1, 1'b1);
        expect_commit("toggle");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/corner_tracker.md
CORNER_TRACKER -- requirements
Module: corner_tracker

Interface
REQ-001 The module SHALL have parameter p_frame_width, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameter p_frame_height, default 480, meaning active lines per frame.
REQ-003 The module SHALL have parameter p_min_count, default 16, meaning the minimum marker pixels per frame for a valid corner set.
REQ-004 The module SHALL have parameters p_r_min = 8'd160, p_g_max = 8'd80 and p_b_max = 8'd80, meaning the marker colour thresholds.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port pixel_valid, input, 1 bit: qualifies the pixel inputs for the current cycle.
REQ-008 The module SHALL have ports VGA_X and VGA_Y, input, 11 bits each, unsigned: coordinate of the current pixel.
REQ-009 The module SHALL have ports pix_R, pix_G and pix_B, input, 8 bits each: colour of the current camera pixel.
REQ-010 The module SHALL have outputs top_left_x/y, top_right_x/y, bot_left_x/y and bot_right_x/y, 11 bits each, unsigned: the registered corners consumed by boundary_select.
REQ-011 The module SHALL have output corners_valid, 1 bit: high when the last committed frame met p_min_count.
REQ-012 The module SHALL have output frame_done, 1 bit: one-cycle pulse on each commit attempt.

Function
REQ-013 A marker pixel SHALL be defined as pixel_valid && pix_R >= p_r_min && pix_G <= p_g_max && pix_B <= p_b_max.
REQ-014 Corner keys SHALL be computed as s = X+Y (12-bit unsigned) and d = X−Y (12-bit signed).
REQ-015 Corner selection SHALL be: top_left = min s; bot_right = max s; top_right = max d; bot_left = min d.
REQ-016 Each corner comparison SHALL be strict, so that on a tie the first pixel in raster order wins.
REQ-017 The FSM SHALL have states IDLE, ACCUM and COMMIT.
REQ-018 IDLE SHALL transition to ACCUM on a valid pixel at (0,0), and SHALL initialise the running extremes and the marker count from that pixel.
REQ-019 In ACCUM, each marker pixel SHALL increment the 19-bit count, saturating at its maximum, and SHALL update the running extremes.
REQ-020 A valid pixel at (0,0) seen in ACCUM SHALL restart accumulation: partial results are discarded, no commit occurs and no frame_done is issued.
REQ-021 A valid pixel at (p_frame_width−1, p_frame_height−1) seen in ACCUM SHALL be included in the accumulation, after which the FSM SHALL enter COMMIT.
REQ-022 COMMIT SHALL last exactly one cycle, SHALL pulse frame_done, and SHALL then return to IDLE.
REQ-023 In COMMIT, if count >= p_min_count, all eight corner outputs SHALL update and corners_valid SHALL go to 1.
REQ-024 In COMMIT, if count < p_min_count, the corner outputs SHALL hold their previous values and corners_valid SHALL go to 0.
REQ-025 Latency SHALL be: corner outputs change on the 2nd rising edge after the edge that samples the last pixel.
REQ-026 Corner outputs SHALL be stable for the whole of the next frame.
REQ-027 Cycles with pixel_valid low SHALL leave all state unchanged.
REQ-028 Coordinates with X >= p_frame_width or Y >= p_frame_height SHALL be ignored.

Reset
REQ-029 While reset is high at a clk edge, the FSM SHALL go to IDLE, the count SHALL clear, and frame_done and corners_valid SHALL go to 0.
REQ-030 On reset, the corner outputs SHALL take these values: top_left = (0,0); top_right = (p_frame_width−1, 0); bot_left = (0, p_frame_height−1); bot_right = (p_frame_width−1, p_frame_height−1).
REQ-031 A reset asserted mid-frame SHALL discard the partial frame; the next commit SHALL require a fresh (0,0) pixel.

Structure
REQ-032 The coordinate width (11), the key width (12), the count width (19) and the default-corner constants SHALL live in the shared project constants file used by boundary_select.
REQ-033 The module SHALL contain one combinational sub-module, marker_classify, which takes the pixel RGB and thresholds and outputs is_marker.
REQ-034 The four corner trackers SHALL be per-corner register pairs (key, x/y) inside corner_tracker.

Verification
REQ-035 Scenario: a frame with a solid marker rectangle spanning x 100..199, y 50..149 -> after the frame, TL = (100,50), TR = (199,50), BL = (100,149), BR = (199,149), corners_valid = 1, and exactly one frame_done pulse.
REQ-036 Scenario: a frame with only 10 marker pixels, preceded by a valid frame -> corners hold the prior values, corners_valid = 0, and frame_done pulses.
REQ-037 Scenario: a single-pixel tie test with markers at (10,20) and (20,10) (both s = 30), then another frame -> top_left = (10,20)? No, first in raster order wins: (20,10), since y = 10 arrives first.
REQ-038 Scenario: (0,0) re-issued at line 200 of a frame carrying markers in lines 0..199 -> no frame_done; the next full frame commits only its own markers.
REQ-039 Scenario: reset pulsed at line 240 mid-frame -> all outputs return to their REQ-029/REQ-030 reset values; the remainder of the frame produces no commit.
REQ-040 Scenario: pixel_valid toggled 50% across a frame carrying the REQ-035 rectangle -> results identical to REQ-035, with commit two edges after the last valid pixel.
